stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency; one count tick every CLK_HZ cycles.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 1000000 (20 ms at 50 MHz), the number of stable cycles needed to accept a key level.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port KEY  input  2  board pushbuttons, active-low, asynchronous; KEY[0] is start/stop, KEY[1] is clear.
REQ-006 SHALL have port bcd_ones  output  4  ones digit, 0-9, to the 7-segment decoder.
REQ-007 SHALL have port bcd_tens  output  4  tens digit, 0-9, to the 7-segment decoder.
REQ-008 SHALL have port running  output  1  high while in RUN.
REQ-009 SHALL have port tick  output  1  one-cycle pulse on the cycle the digits increment.

Function
REQ-010 SHALL pass each KEY bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL treat a press as a 1-to-0 transition of the accepted (debounced) key level, producing a one-cycle press pulse; holding a key produces no further pulses.
REQ-012 SHALL use an FSM with states IDLE, RUN and PAUSE; reset enters IDLE.
REQ-013 SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN on a start/stop press.
REQ-014 SHALL, on a clear press in any state, go to IDLE, set both digits to 0 and zero the prescaler on the next edge.
REQ-015 SHALL give clear priority when clear and start/stop presses occur in the same cycle; start/stop is then ignored.
REQ-016 SHALL count the prescaler 0..CLK_HZ-1 only in RUN, and wrap it to 0 while asserting tick for that cycle.
REQ-017 SHALL freeze the prescaler in PAUSE, without clearing it, so a resumed second completes the remaining fraction.
REQ-018 SHALL, on tick, increment the digits: if ones<9, ones+1; if ones=9, ones=0 and tens+1; 99 wraps to 00 with no extra flag.
REQ-019 SHALL change the digits on the same edge that tick is asserted; bcd outputs are registered with no combinational path from KEY.
REQ-020 SHALL drive running combinationally from the state register (RUN only).

Reset
REQ-021 SHALL, on RESET, asynchronously force state=IDLE, bcd_ones=0, bcd_tens=0, tick=0, running=0, prescaler=0, debounce counters=0, synchronizers and accepted key levels=1 (released).
REQ-022 SHALL emit no press pulse on reset release while keys are held; a press needs a released-then-pressed sequence.
REQ-023 SHALL abandon any in-progress count or debounce when RESET is asserted mid-operation, with no residual pulse.

Configuration
REQ-024 SHALL implement debouncing when STOPWATCH_DEBOUNCE_EN is defined: the accepted level updates only after the synchronized level differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
REQ-025 SHALL, without STOPWATCH_DEBOUNCE_EN, use the synchronized level directly as the accepted level, with no debounce counters and DEBOUNCE_CYC unused.

Structure
REQ-026 SHALL place the state enum (IDLE/RUN/PAUSE) and the BCD digit max constant (9) in shared package stopwatch_pkg.
REQ-027 SHALL implement the synchronizer, debounce and press-edge logic as one sub-module key_press, instantiated once per key.

Verification (CLK_HZ=10, DEBOUNCE_CYC=4)
REQ-028 SHALL cover: reset, press KEY[0] -> running=1; after 10 cycles tick pulses once and the digits read 01; after 100 ticks the digits read 00.
REQ-029 SHALL cover: at digits 09 with a tick -> 10; at 99 with a tick -> 00.
REQ-030 SHALL cover: press KEY[0] at prescaler=6 -> PAUSE and digits hold; press again -> tick after 4 more RUN cycles.
REQ-031 SHALL cover: clear and start/stop pressed in the same cycle while in RUN -> IDLE, digits 00, running=0.
REQ-032 SHALL cover: with debounce enabled, KEY[0] bounces 0/1 every 2 cycles for 20 cycles then is held low -> exactly one press, 6 cycles after the final fall (2 sync + 4 debounce).
REQ-033 SHALL cover: RESET asserted mid-RUN at digits 37 -> outputs 00, running=0 immediately; KEY[0] held low through reset release -> no start until it is released and pressed again.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the two-digit BCD stopwatch.
// Holds the controller state enum and the BCD increment helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Next value of the {tens, ones} pair; 99 rolls over to 00.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] nxt;
        if (ones < BCD_MAX) begin
            nxt = {tens, ones + 4'd1};
        end else if (tens < BCD_MAX) begin
            nxt = {tens + 4'd1, 4'd0};
        end else begin
            nxt = 8'd0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Board-side signal bundle of the stopwatch: pushbuttons in, digits and status out.
// The slave modport is the stopwatch itself; master is whatever drives the keys.
interface stopwatch_ctrl_if;

    logic [1:0] KEY;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic       running;
    logic       tick;

    modport master (
        output KEY,
        input  bcd_ones,
        input  bcd_tens,
        input  running,
        input  tick
    );

    modport slave (
        input  KEY,
        output bcd_ones,
        output bcd_tens,
        output running,
        output tick
    );

endinterface

// File: rtl/stopwatch_ctrl_key_press.sv
// Per-key front end: 2-flop synchronizer, optional debounce, one-cycle press pulse.
// Debouncing is built only when STOPWATCH_DEBOUNCE_EN is defined.
module key_press #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_n,
    output logic press
);

    logic       sync1;
    logic       sync2;
    logic [1:0] valid_q;
    logic       armed;
    logic       level_prev;
    logic       level;

    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("key_press: DEBOUNCE_CYC must be at least 1");
    end

    // A press is only honoured once a genuinely sampled released level has been
    // seen, so a key held through reset release cannot fire.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            valid_q    <= 2'b00;
            armed      <= 1'b0;
            level_prev <= 1'b1;
        end else begin
            sync1      <= key_n;
            sync2      <= sync1;
            valid_q    <= {valid_q[0], 1'b1};
            level_prev <= level;
            if (valid_q[1] && sync2) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] stable_cnt;
    logic          level_q;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            level_q    <= 1'b1;
            stable_cnt <= '0;
        end else if (sync2 != level_q) begin
            if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level_q    <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    assign level = level_q;
`else
    assign level = sync2;
`endif

    assign press = armed & level_prev & ~level;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch: KEY[0] start/stop, KEY[1] clear, one count per CLK_HZ cycles.
// Define STOPWATCH_DEBOUNCE_EN to debounce the keys over DEBOUNCE_CYC cycles.
module stopwatch_ctrl #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    stopwatch_ctrl_if.slave sw
);
    import stopwatch_pkg::*;

    localparam int            PW            = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_HZ - 1);

    sw_state_t     state;
    logic [PW-1:0] prescaler;
    logic [3:0]    ones;
    logic [3:0]    tens;
    logic          tick_q;
    logic          start_press;
    logic          clear_press;

    if (CLK_HZ < 1) begin : g_bad_clk
        $error("stopwatch_ctrl: CLK_HZ must be at least 1");
    end

    key_press #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_start (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .key_n    (sw.KEY[0]),
        .press    (start_press)
    );

    key_press #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_clear (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .key_n    (sw.KEY[1]),
        .press    (clear_press)
    );

    // Clear wins over start/stop; a start/stop edge freezes the prescaler for that
    // cycle so a pause taken at prescaler=N resumes from exactly N.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            prescaler <= '0;
            ones      <= 4'd0;
            tens      <= 4'd0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (clear_press) begin
                state     <= IDLE;
                prescaler <= '0;
                ones      <= 4'd0;
                tens      <= 4'd0;
            end else if (start_press) begin
                case (state)
                    IDLE:    state <= RUN;
                    RUN:     state <= PAUSE;
                    PAUSE:   state <= RUN;
                    default: state <= IDLE;
                endcase
            end else if (state == RUN) begin
                if (prescaler == PRESCALE_LAST) begin
                    prescaler    <= '0;
                    tick_q       <= 1'b1;
                    {tens, ones} <= bcd_inc(tens, ones);
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    assign sw.bcd_ones = ones;
    assign sw.bcd_tens = tens;
    assign sw.tick     = tick_q;
    assign sw.running  = (state == RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (CLK_HZ=10, DEBOUNCE_CYC=4) against a cycle model.
// The bounce scenario is exercised only when STOPWATCH_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    localparam int CLK_HZ       = 10;
    localparam int DEBOUNCE_CYC = 4;
    localparam int HOLD         = 10;
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif
    // Cycles from a key edge to the press pulse: 2 sync (+ DEBOUNCE_CYC when debouncing)
    localparam int LAT = DEB_EN ? (2 + DEBOUNCE_CYC) : 2;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b0;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .sw       (sw)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: key history, per-key acceptance state, elapsed seconds 0..99
    logic [1:0] key_hist[$];
    bit         m_armed[2];
    bit         m_prev[2];
    bit         m_acc[2];
    int         m_diff[2];
    int         m_state;
    int         m_pre;
    int         m_count;
    bit         m_tick;

    function automatic void model_reset();
        key_hist.delete();
        for (int k = 0; k < 2; k++) begin
            m_armed[k] = 1'b0;
            m_prev[k]  = 1'b1;
            m_acc[k]   = 1'b1;
            m_diff[k]  = 0;
        end
        m_state = 0;
        m_pre   = 0;
        m_count = 0;
        m_tick  = 1'b0;
    endfunction

    function automatic void model_step(input logic [1:0] key);
        logic [1:0] synced;
        bit         press[2];
        bit         acc;
        synced = (key_hist.size() >= 2) ? key_hist[key_hist.size() - 2] : 2'b11;
        for (int k = 0; k < 2; k++) begin
            acc      = DEB_EN ? m_acc[k] : synced[k];
            press[k] = m_armed[k] && m_prev[k] && !acc;
            m_prev[k] = acc;
            if (key_hist.size() >= 2 && synced[k]) m_armed[k] = 1'b1;
            if (synced[k] != m_acc[k]) begin
                m_diff[k]++;
                if (m_diff[k] == DEBOUNCE_CYC) begin
                    m_acc[k]  = synced[k];
                    m_diff[k] = 0;
                end
            end else begin
                m_diff[k] = 0;
            end
        end
        key_hist.push_back(key);
        if (key_hist.size() > 2) void'(key_hist.pop_front());

        m_tick = 1'b0;
        if (press[1]) begin
            m_state = 0;
            m_pre   = 0;
            m_count = 0;
        end else if (press[0]) begin
            m_state = (m_state == 1) ? 2 : 1;
        end else if (m_state == 1) begin
            if (m_pre == CLK_HZ - 1) begin
                m_pre   = 0;
                m_tick  = 1'b1;
                m_count = (m_count + 1) % 100;
            end else begin
                m_pre++;
            end
        end
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(m_count / 10);
        o = 4'(m_count % 10);
        return {t, o, (m_state == 1), m_tick};
    endfunction

    function automatic logic [9:0] obs();
        return {sw.bcd_tens, sw.bcd_ones, sw.running, sw.tick};
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        model_step(sw.KEY);
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        #1;
        RESET  = 1'b1;
        sw.KEY = 2'b11;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (4) begin
            step();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL post_reset got=%h want=%h", obs(), exp_vec());
            end
        end
    endtask

    task automatic tap(input int k, input int hold);
        sw.KEY[k] = 1'b0;
        repeat (hold) begin
            step();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL tap_low got=%h want=%h", obs(), exp_vec());
            end
        end
        sw.KEY[k] = 1'b1;
        repeat (hold) begin
            step();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL tap_high got=%h want=%h", obs(), exp_vec());
            end
        end
    endtask

    task automatic test_reset();
        RESET  = 1'b1;
        sw.KEY = 2'b11;
        #1;
        vectors++;
        if (obs() !== 10'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got=%h want=%h", obs(), 10'h000);
        end
        do_reset();
    endtask

    task automatic test_start_tick();
        int n;
        int ticks;
        do_reset();
        sw.KEY[0] = 1'b0;
        n = 0;
        while (sw.running !== 1'b1 && n < 20) begin
            step();
            n++;
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL start_model got=%h want=%h", obs(), exp_vec());
            end
        end
        vectors++;
        if (n !== LAT + 1) begin
            miscompares++;
            $display("[TB] FAIL start_latency got=%0d want=%0d", n, LAT + 1);
        end
        sw.KEY[0] = 1'b1;
        n = 0;
        while (sw.tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (n !== CLK_HZ || {sw.bcd_tens, sw.bcd_ones} !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL first_tick cycles=%0d digits=%h want cycles=%0d digits=01",
                     n, {sw.bcd_tens, sw.bcd_ones}, CLK_HZ);
        end
        ticks = 1;
        n = 0;
        while (ticks < 100 && n < 1200) begin
            step();
            n++;
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL count_model got=%h want=%h", obs(), exp_vec());
            end
            if (m_tick) begin
                ticks++;
                if (ticks == 9 || ticks == 10 || ticks == 99 || ticks == 100) begin
                    vectors++;
                    if ({sw.bcd_tens, sw.bcd_ones} !== 8'((ticks / 10 % 10) * 16 + ticks % 10)) begin
                        miscompares++;
                        $display("[TB] FAIL digits_at_tick%0d got=%h want=%h", ticks,
                                 {sw.bcd_tens, sw.bcd_ones}, 8'((ticks / 10 % 10) * 16 + ticks % 10));
                    end
                end
            end
        end
        vectors++;
        if (ticks !== 100) begin
            miscompares++;
            $display("[TB] FAIL hundred_ticks got=%0d want=100", ticks);
        end
    endtask

    task automatic test_pause();
        int n;
        do_reset();
        tap(0, HOLD);
        n = 0;
        while (m_pre != 6 - LAT && n < 30) begin
            step();
            n++;
        end
        sw.KEY[0] = 1'b0;
        n = 0;
        while (sw.running !== 1'b0 && n < 20) begin
            step();
            n++;
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL pause_model got=%h want=%h", obs(), exp_vec());
            end
        end
        vectors++;
        if (n !== LAT + 1) begin
            miscompares++;
            $display("[TB] FAIL pause_latency got=%0d want=%0d", n, LAT + 1);
        end
        repeat (HOLD) step();
        sw.KEY[0] = 1'b1;
        repeat (15) begin
            step();
            vectors++;
            if (obs() !== exp_vec() || sw.tick !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL pause_hold got=%h want=%h", obs(), exp_vec());
            end
        end
        sw.KEY[0] = 1'b0;
        n = 0;
        while (sw.running !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n = 0;
        while (sw.tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("[TB] FAIL resume_remaining got=%0d want=4", n);
        end
        sw.KEY[0] = 1'b1;
        repeat (HOLD) step();
    endtask

    task automatic test_clear_priority();
        int n;
        do_reset();
        tap(0, HOLD);
        repeat (25) step();
        sw.KEY = 2'b00;
        n = 0;
        while (sw.running !== 1'b0 && n < 20) begin
            step();
            n++;
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL clear_model got=%h want=%h", obs(), exp_vec());
            end
        end
        vectors++;
        if (n !== LAT + 1 || {sw.bcd_tens, sw.bcd_ones, sw.running} !== 9'h000) begin
            miscompares++;
            $display("[TB] FAIL clear_priority cycles=%0d outs=%h want cycles=%0d outs=000",
                     n, {sw.bcd_tens, sw.bcd_ones, sw.running}, LAT + 1);
        end
        repeat (HOLD) step();
        sw.KEY = 2'b11;
        repeat (HOLD) begin
            step();
            vectors++;
            if (obs() !== 10'h000) begin
                miscompares++;
                $display("[TB] FAIL clear_stays_idle got=%h want=000", obs());
            end
        end
    endtask

`ifdef STOPWATCH_DEBOUNCE_EN
    task automatic test_bounce();
        int n;
        int rises;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            sw.KEY[0] = ((i / 2) % 2 == 1);
            step();
            vectors++;
            if (obs() !== 10'h000) begin
                miscompares++;
                $display("[TB] FAIL bounce_no_press got=%h want=000", obs());
            end
        end
        sw.KEY[0] = 1'b0;
        n = 0;
        while (sw.running !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        // press pulse lands 6 cycles after the fall; running follows one edge later
        vectors++;
        if (n !== 7) begin
            miscompares++;
            $display("[TB] FAIL bounce_latency got=%0d want=7", n);
        end
        rises = 0;
        repeat (20) begin
            step();
            if (sw.running !== 1'b1) rises++;
        end
        vectors++;
        if (rises !== 0) begin
            miscompares++;
            $display("[TB] FAIL bounce_single_press got=%0d want=0", rises);
        end
        sw.KEY[0] = 1'b1;
        repeat (HOLD) step();
    endtask
`endif

    task automatic test_reset_mid_run();
        int n;
        do_reset();
        tap(0, HOLD);
        n = 0;
        while (m_count != 37 && n < 500) begin
            step();
            n++;
        end
        vectors++;
        if ({sw.bcd_tens, sw.bcd_ones} !== 8'h37) begin
            miscompares++;
            $display("[TB] FAIL reach_37 got=%h want=37", {sw.bcd_tens, sw.bcd_ones});
        end
        sw.KEY[0] = 1'b0;
        #1;
        RESET = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (obs() !== 10'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_run got=%h want=000", obs());
        end
        repeat (2) @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (20) begin
            step();
            vectors++;
            if (obs() !== exp_vec() || sw.running !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL held_key_no_start got=%h want=%h", obs(), exp_vec());
            end
        end
        sw.KEY[0] = 1'b1;
        repeat (HOLD) step();
        tap(0, HOLD);
        vectors++;
        if (sw.running !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_after_release got=%b want=1", sw.running);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (60) begin
            sw.KEY[0] = 1'($urandom_range(0, 1));
            sw.KEY[1] = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            repeat ($urandom_range(1, 12)) begin
                step();
                vectors++;
                if (obs() !== exp_vec()) begin
                    miscompares++;
                    $display("[TB] FAIL random_model got=%h want=%h", obs(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        sw.KEY = 2'b11;
        test_reset();
        test_start_tick();
        test_pause();
        test_clear_priority();
`ifdef STOPWATCH_DEBOUNCE_EN
        test_bounce();
`endif
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
